uart_frame_rx: RTL and testbench
================================

# uart_frame_rx

Receive-side frame parser between the UART receive FIFO read port (`r_data`/`rd_uart`/`rx_empty`) and the core logic. It pops bytes from the FIFO and hunts for a start-of-frame byte. It then collects a length-prefixed payload into an internal buffer and checks an XOR checksum. Only frames that pass the checksum are replayed on a valid/ready byte stream; malformed, corrupt or stalled frames are dropped and flagged.

## Interface
- `DBITS`, 8, byte width; must equal the UART data width.
- `MAX_LEN`, 16, largest accepted payload length in bytes (1..255).
- `SOF`, 8'hA5, start-of-frame byte value.
- `TIMEOUT_CYCLES`, 100000, maximum clock cycles allowed between consecutive bytes inside a frame.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `r_data`  in  DBITS  byte from the receive FIFO; valid the cycle after `rd_uart`.
- `rx_empty`  in  1  receive FIFO empty.
- `rd_uart`  out  1  single-cycle FIFO pop request.
- `m_data`  out  DBITS  payload byte output.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  downstream accepts the byte.
- `m_last`  out  1  marks the final payload byte of a frame.
- `frame_ok`  out  1  one-cycle pulse when the checksum passes.
- `err_len`  out  1  one-cycle pulse on a LEN of 0 or a LEN above MAX_LEN.
- `err_csum`  out  1  one-cycle pulse on a checksum mismatch.
- `err_timeout`  out  1  one-cycle pulse on an inter-byte timeout.
- `busy`  out  1  high whenever the state is not HUNT.

## Operation
- **Byte fetch unit**
  - Enabled only in the HUNT, LEN, PAYLOAD and CSUM states.
  - When enabled, `rx_empty`=0 and no read is outstanding: assert `rd_uart` for 1 cycle.
  - On the next cycle, `byte_valid`=1 and `r_data` is captured.
  - Maximum rate is one byte per 2 cycles.
  - `rd_uart` is never asserted in the EMIT state.
- **State machine**
  - **HUNT**: discard bytes until one equals `SOF`, then go to LEN.
  - **LEN**:
    - If the byte is 0 or greater than MAX_LEN: pulse `err_len` and go to HUNT.
    - Otherwise: store `len`, set `csum_acc`=byte, clear `idx`, and go to PAYLOAD.
  - **PAYLOAD**:
    - Each byte is written to `buf[idx]`, then `csum_acc ^= byte` and `idx++`.
    - When `idx` reaches `len`, go to CSUM.
  - **CSUM**:
    - If `csum_acc ^ byte` is 0: pulse `frame_ok`, clear `idx`, and go to EMIT.
    - Otherwise: pulse `err_csum` and go to HUNT.
  - **EMIT**:
    - `m_valid`=1, `m_data`=`buf[idx]`, `m_last`=(`idx`==`len`-1).
    - On `m_valid && m_ready`: `idx++`.
    - On the handshake of the last byte: go to HUNT.
- **Data stability**: `m_data` and `m_last` hold stable while `m_valid`=1 and `m_ready`=0. Both outputs are 0 whenever `m_valid`=0.
- **Timeout counter**
  - Width is `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared on every `byte_valid` and when in HUNT or EMIT.
  - Increments every cycle in LEN, PAYLOAD and CSUM.
  - When it reaches TIMEOUT_CYCLES-1 with no `byte_valid` that cycle: pulse `err_timeout`, go to HUNT, and discard the partial frame.
  - If `byte_valid` and expiry occur in the same cycle, the byte wins.
- **SOF inside a frame**: an SOF byte seen in LEN, PAYLOAD or CSUM is ordinary data. There is no resynchronisation mid-frame.
- **Error exclusivity**: at most one of `frame_ok`, `err_len`, `err_csum` and `err_timeout` is high in any cycle.

## Timing
- **Reset values**: after `reset_n`=0 at a clock edge:
  - State is HUNT.
  - `rd_uart`, `m_valid`, `m_last`, `frame_ok`, all error outputs and `busy` are 0.
  - `m_data` is 0.
  - The outstanding-read flag and the timeout counter are cleared.
  - The buffer contents are don't-care.
- **Reset mid-frame**: any fetched byte is discarded and no pulse is generated.
- **Output pulses**: `frame_ok` and the error outputs are registered and appear the cycle after the `byte_valid` that decided them. The state change happens on the same edge.
- **First valid byte**: `m_valid` rises on the cycle after `frame_ok`. Minimum latency from the CSUM-byte `rd_uart` to the first `m_valid` is 3 cycles.
- **Output rate**: with `m_ready` held at 1, EMIT produces one byte per cycle. A frame of length N occupies EMIT for exactly N cycles.
- **Back-to-back frames**: the first `rd_uart` of the next frame can occur on the cycle after the last EMIT handshake.

## Test plan
- **Good frame**: FIFO holds A5 03 11 22 33 03 -> `frame_ok` pulses once; `m_data` carries 11, 22, 33 on consecutive `m_ready` cycles; `m_last` is set only with 33; no error pulses.
- **Leading garbage and back-to-back frames**: 00 FF 5A A5 01 7E 7F followed by A5 01 42 43 -> garbage is skipped; output is 7E(last), then 42(last); `frame_ok` pulses twice.
- **Bad checksum**: A5 03 11 22 33 04 -> `err_csum` pulses; `m_valid` never rises; the next good frame is delivered normally.
- **Length errors**: A5 00 pulses `err_len`; with MAX_LEN=16, A5 11 pulses `err_len`; in both cases the following bytes are hunted for SOF.
- **Timeout and reset**: with TIMEOUT_CYCLES=50, send A5 02 11 and then nothing -> `err_timeout` pulses 50 cycles after the 11 was captured, and `busy` falls. Separately, asserting `reset_n`=0 during PAYLOAD sets all outputs to 0 with no pulse.
- **Backpressure**: good frame of length 4 with `m_ready` toggling 1,0,0,1,... -> each byte is held stable while stalled; exactly 4 handshakes occur; no `rd_uart` during EMIT even with `rx_empty`=0.

Source files
------------

// File: rtl/uart_frame_rx.sv
// Receive-side frame parser: pops bytes from the UART RX FIFO, validates SOF/LEN/payload/XOR
// checksum frames and replays accepted payloads on a valid/ready byte stream.
module uart_frame_rx #(
  parameter int unsigned       DBITS          = 8,
  parameter int unsigned       MAX_LEN        = 16,
  parameter logic [DBITS-1:0]  SOF            = 8'hA5,
  parameter int unsigned       TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DBITS-1:0] r_data,
  input  logic             rx_empty,
  output logic             rd_uart,
  output logic [DBITS-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             frame_ok,
  output logic             err_len,
  output logic             err_csum,
  output logic             err_timeout,
  output logic             busy
);

  localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned IW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, EMIT} state_t;

  state_t           state, state_n;
  logic             byte_valid;
  logic [IW-1:0]    len, len_n;
  logic [IW-1:0]    idx, idx_n;
  logic [IW-1:0]    emit_idx;
  logic [DBITS-1:0] csum_acc, csum_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic             rd_n, m_valid_n, m_last_n;
  logic [DBITS-1:0] m_data_n;
  logic             ok_n, elen_n, ecs_n, eto_n;
  logic             wr_en;

  logic [DBITS-1:0] buf_mem [DEPTH];

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[idx[AW-1:0]] <= r_data;
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_n   = state;
    len_n     = len;
    idx_n     = idx;
    csum_n    = csum_acc;
    tcnt_n    = tcnt;
    m_valid_n = m_valid;
    m_data_n  = m_data;
    m_last_n  = m_last;
    ok_n      = 1'b0;
    elen_n    = 1'b0;
    ecs_n     = 1'b0;
    eto_n     = 1'b0;
    wr_en     = 1'b0;
    emit_idx  = m_valid ? idx + IW'(1) : idx;

    case (state)
      HUNT: begin
        tcnt_n = '0;
        if (byte_valid && r_data == SOF) state_n = LEN;
      end
      LEN: begin
        if (byte_valid) begin
          if (r_data == '0 || r_data > DBITS'(MAX_LEN)) begin
            elen_n  = 1'b1;
            state_n = HUNT;
          end else begin
            len_n   = IW'(r_data);
            csum_n  = r_data;
            idx_n   = '0;
            state_n = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_valid) begin
          wr_en  = 1'b1;
          csum_n = csum_acc ^ r_data;
          idx_n  = idx + IW'(1);
          if (idx + IW'(1) == len) state_n = CSUM;
        end
      end
      CSUM: begin
        if (byte_valid) begin
          if ((csum_acc ^ r_data) == '0) begin
            ok_n    = 1'b1;
            idx_n   = '0;
            state_n = EMIT;
          end else begin
            ecs_n   = 1'b1;
            state_n = HUNT;
          end
        end
      end
      EMIT: begin
        tcnt_n = '0;
        // Output register is loaded when empty or when its byte is accepted.
        if (!m_valid || m_ready) begin
          if (m_valid && m_last) begin
            m_valid_n = 1'b0;
            m_data_n  = '0;
            m_last_n  = 1'b0;
            state_n   = HUNT;
          end else begin
            idx_n     = emit_idx;
            m_valid_n = 1'b1;
            m_data_n  = buf_mem[emit_idx[AW-1:0]];
            m_last_n  = (emit_idx == len - IW'(1));
          end
        end
      end
      default: state_n = HUNT;
    endcase

    // Inter-byte timeout; a byte arriving in the expiry cycle takes priority.
    if (state inside {LEN, PAYLOAD, CSUM}) begin
      if (byte_valid) begin
        tcnt_n = '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        eto_n   = 1'b1;
        state_n = HUNT;
        tcnt_n  = '0;
      end else begin
        tcnt_n = tcnt + TW'(1);
      end
    end

    rd_n = (state_n inside {HUNT, LEN, PAYLOAD, CSUM}) && !rx_empty && !rd_uart;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= HUNT;
      byte_valid  <= 1'b0;
      len         <= '0;
      idx         <= '0;
      csum_acc    <= '0;
      tcnt        <= '0;
      rd_uart     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      frame_ok    <= 1'b0;
      err_len     <= 1'b0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      byte_valid  <= rd_uart;
      len         <= len_n;
      idx         <= idx_n;
      csum_acc    <= csum_n;
      tcnt        <= tcnt_n;
      rd_uart     <= rd_n;
      m_valid     <= m_valid_n;
      m_data      <= m_data_n;
      m_last      <= m_last_n;
      frame_ok    <= ok_n;
      err_len     <= elen_n;
      err_csum    <= ecs_n;
      err_timeout <= eto_n;
      busy        <= (state_n != HUNT);
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed self-checking bench for uart_frame_rx with a registered-output FIFO model.
module tb_uart_frame_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] r_data = 8'h00;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       m_last;
  logic       frame_ok, err_len, err_csum, err_timeout, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] seq[$];
  logic [7:0] exp_d[$];
  bit         exp_l[$];
  logic [7:0] hs_d[$];
  bit         hs_l[$];
  int         hs_cyc[$], vcyc_q[$], ok_q[$], ok_rd_q[$];
  int         elen_q[$], ecs_q[$], eto_q[$], rd_q[$];
  bit         eto_busy_q[$];

  logic       mon_en = 1'b0;
  logic       bp_mode = 1'b0;
  logic [3:0] pat = 4'b1001;
  logic [1:0] bp_idx = 2'd0;
  logic       rdy_c;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out = 9'd0;
  int         last_rd_cyc = 0;

  assign rx_empty = (push_cnt == pop_cnt);
  assign rdy_c    = bp_mode ? pat[bp_idx] : 1'b1;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .DBITS(8), .MAX_LEN(16), .SOF(8'hA5), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset_n(reset_n), .r_data(r_data), .rx_empty(rx_empty),
    .rd_uart(rd_uart), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .frame_ok(frame_ok), .err_len(err_len), .err_csum(err_csum),
    .err_timeout(err_timeout), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // FIFO read port: data appears the cycle after the pop request.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_uart && fifo_q.size() != 0) begin
      r_data  <= fifo_q.pop_front();
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Output monitor: drives m_ready, logs events, checks stream invariants every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      m_ready <= rdy_c;
      bp_idx  <= bp_idx + 2'd1;
      if (m_valid && rdy_c) begin
        hs_d.push_back(m_data);
        hs_l.push_back(m_last);
        hs_cyc.push_back(cyc);
      end
      if (m_valid) begin
        vcyc_q.push_back(cyc);
        check("no_rd_in_emit", 32'(rd_uart), 32'd0);
      end else begin
        check("idle_out_zero", 32'({m_data, m_last}), 32'd0);
      end
      if (prev_stall) check("hold_stable", 32'({m_data, m_last}), 32'(prev_out));
      prev_stall <= m_valid && !rdy_c;
      prev_out   <= {m_data, m_last};
      check("pulse_excl", 32'($countones({frame_ok, err_len, err_csum, err_timeout}) <= 1), 32'd1);
      if (frame_ok) begin
        ok_q.push_back(cyc);
        ok_rd_q.push_back(last_rd_cyc);
        check("no_rd_at_ok", 32'(rd_uart), 32'd0);
      end
      if (err_len)  elen_q.push_back(cyc);
      if (err_csum) ecs_q.push_back(cyc);
      if (err_timeout) begin
        eto_q.push_back(cyc);
        eto_busy_q.push_back(busy);
      end
      if (rd_uart) begin
        rd_q.push_back(cyc);
        last_rd_cyc <= cyc;
      end
    end
  end

  task automatic push_seq(input logic [7:0] s[$]);
    foreach (s[i]) begin
      fifo_q.push_back(s[i]);
      push_cnt++;
    end
  endtask

  task automatic clear_logs();
    hs_d.delete(); hs_l.delete(); hs_cyc.delete(); vcyc_q.delete();
    ok_q.delete(); ok_rd_q.delete(); elen_q.delete(); ecs_q.delete();
    eto_q.delete(); eto_busy_q.delete(); rd_q.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_empty && !busy && !rd_uart && !m_valid) quiet++;
      else quiet = 0;
      if (quiet >= 4) return;
    end
    check("idle_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 32'(hs_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < hs_d.size(); i++) begin
      check({tag, "_data"}, 32'(hs_d[i]), 32'(exp_d[i]));
      check({tag, "_last"}, 32'(hs_l[i]), 32'(exp_l[i]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_uart", 32'(rd_uart), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_frame_ok", 32'(frame_ok), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_err_csum", 32'(err_csum), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);

    // Good frame, ready held high.
    clear_logs();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    push_seq(seq);
    wait_idle(400);
    exp_d = '{8'h11, 8'h22, 8'h33};
    exp_l = '{1'b0, 1'b0, 1'b1};
    check_stream("good");
    check("good_ok", 32'(ok_q.size()), 32'd1);
    check("good_errs", 32'(elen_q.size() + ecs_q.size() + eto_q.size()), 32'd0);
    check("good_vcycles", 32'(vcyc_q.size()), 32'd3);
    if (vcyc_q.size() == 3 && ok_q.size() == 1) begin
      check("good_valid_after_ok", 32'(vcyc_q[0] - ok_q[0]), 32'd1);
      check("good_latency", 32'(vcyc_q[0] - ok_rd_q[0]), 32'd3);
      check("good_burst", 32'(vcyc_q[2] - vcyc_q[0]), 32'd2);
    end

    // Leading garbage, back-to-back frames, SOF bytes as payload.
    clear_logs();
    seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F,
            8'hA5, 8'h01, 8'h42, 8'h43, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
    push_seq(seq);
    wait_idle(400);
    exp_d = '{8'h7E, 8'h42, 8'hA5, 8'hA5};
    exp_l = '{1'b1, 1'b1, 1'b0, 1'b1};
    check_stream("b2b");
    check("b2b_ok", 32'(ok_q.size()), 32'd3);
    check("b2b_errs", 32'(elen_q.size() + ecs_q.size() + eto_q.size()), 32'd0);
    if (hs_cyc.size() > 0) begin
      int gap = -1;
      foreach (rd_q[i]) if (gap < 0 && rd_q[i] > hs_cyc[0]) gap = rd_q[i] - hs_cyc[0];
      check("b2b_rd_gap", 32'(gap), 32'd1);
    end

    // Bad checksum followed by a good frame.
    clear_logs();
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04,
            8'hA5, 8'h02, 8'h55, 8'h66, 8'h31};
    push_seq(seq);
    wait_idle(400);
    exp_d = '{8'h55, 8'h66};
    exp_l = '{1'b0, 1'b1};
    check_stream("csum");
    check("csum_err", 32'(ecs_q.size()), 32'd1);
    check("csum_ok", 32'(ok_q.size()), 32'd1);
    check("csum_vcycles", 32'(vcyc_q.size()), 32'd2);

    // Length 0 and MAX_LEN+1 rejected; length 1 and MAX_LEN accepted.
    clear_logs();
    seq = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h99, 8'h98, 8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) seq.push_back(8'(i));
    seq.push_back(8'h10);
    push_seq(seq);
    wait_idle(600);
    exp_d = '{8'h99};
    exp_l = '{1'b1};
    for (int i = 0; i < 16; i++) begin
      exp_d.push_back(8'(i));
      exp_l.push_back(i == 15);
    end
    check_stream("len");
    check("len_err", 32'(elen_q.size()), 32'd2);
    check("len_ok", 32'(ok_q.size()), 32'd2);
    check("len_other_errs", 32'(ecs_q.size() + eto_q.size()), 32'd0);

    // Inter-byte timeout mid-payload.
    clear_logs();
    seq = '{8'hA5, 8'h02, 8'h11};
    push_seq(seq);
    wait_idle(400);
    check("to_pulses", 32'(eto_q.size()), 32'd1);
    check("to_rds", 32'(rd_q.size()), 32'd3);
    if (eto_q.size() == 1 && rd_q.size() == 3) begin
      check("to_delay", 32'(eto_q[0] - rd_q[2]), 32'd52);
      check("to_busy_low", 32'(eto_busy_q[0]), 32'd0);
    end
    check("to_no_ok", 32'(ok_q.size() + hs_d.size()), 32'd0);

    // Reset in the middle of a payload.
    clear_logs();
    seq = '{8'hA5, 8'h04, 8'h11, 8'h22};
    push_seq(seq);
    repeat (14) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ctl", 32'({rd_uart, m_valid, m_last, frame_ok, err_len,
                              err_csum, err_timeout, busy}), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    reset_n = 1'b1;
    repeat (70) @(negedge clk);
    check("mid_no_pulse", 32'(ok_q.size() + elen_q.size() + ecs_q.size() + eto_q.size()), 32'd0);
    check("mid_busy_low", 32'(busy), 32'd0);

    // Backpressure with the FIFO still holding bytes during EMIT.
    clear_logs();
    bp_mode = 1'b1;
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_seq(seq);
    wait_idle(400);
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("bp");
    check("bp_ok", 32'(ok_q.size()), 32'd1);
    check("bp_stalled", 32'(vcyc_q.size() > 4), 32'd1);
    bp_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
